// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem req/ready handshake and a one-entry
// IF/ID register with valid/ready flow control toward decode.

module adder_64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum
);
    // 16-bit slices chained by carry; the final carry-out is intentionally dropped (mod 2^64).
    logic [3:0] carry;
    assign carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            if (gi < 3) begin : g_mid
                logic [16:0] part;
                assign part = {1'b0, a[gi*16 +: 16]} + {1'b0, b[gi*16 +: 16]} + {16'd0, carry[gi]};
                assign sum[gi*16 +: 16] = part[15:0];
                assign carry[gi+1] = part[16];
            end else begin : g_top
                assign sum[gi*16 +: 16] = a[gi*16 +: 16] + b[gi*16 +: 16] + {15'd0, carry[gi]};
            end
        end
    endgenerate
endmodule

module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_taken,
    input  logic [63:0] br_base_pc,
    input  logic [63:0] br_offset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [63:0] out_pc_plus4,
    output logic [31:0] out_instr
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic [63:0] pc_reg;
    logic [63:0] pc_plus4;
    logic [63:0] target_sum;
    logic [63:0] br_target;
    logic        valid_reg;
    logic [63:0] opc_reg;
    logic [63:0] opc4_reg;
    logic [31:0] instr_reg;
    logic        slot_free;
    logic        accept;

    adder_64 u_pc_inc (
        .a   (pc_reg),
        .b   (64'd4),
        .sum (pc_plus4)
    );

    adder_64 u_br_tgt (
        .a   (br_base_pc),
        .b   (br_offset),
        .sum (target_sum)
    );

    assign br_target = target_sum & ~64'd3;
    assign slot_free = !valid_reg || out_ready;
    // Gating with reset keeps the request low while reset is being applied.
    assign imem_req  = reset && (state_reg == ST_FETCH) && slot_free;
    assign accept    = imem_req && imem_ready && !br_taken;

    assign imem_addr    = pc_reg;
    assign out_valid    = valid_reg;
    assign out_pc       = opc_reg;
    assign out_pc_plus4 = opc4_reg;
    assign out_instr    = instr_reg;

    always_comb begin
        state_next = state_reg;
        if (br_taken) begin
            state_next = ST_FETCH;
        end else begin
            case (state_reg)
                ST_IDLE:  state_next = ST_FETCH;
                ST_FETCH: if (!slot_free) state_next = ST_HOLD;
                ST_HOLD:  if (out_ready) state_next = ST_FETCH;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
            valid_reg <= 1'b0;
            opc_reg   <= 64'd0;
            opc4_reg  <= 64'd0;
            instr_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (br_taken) begin
                pc_reg    <= br_target;
                valid_reg <= 1'b0;
            end else if (accept) begin
                // Consume and reload in the same edge when decode is also taking the old entry.
                pc_reg    <= pc_plus4;
                valid_reg <= 1'b1;
                opc_reg   <= pc_reg;
                opc4_reg  <= pc_plus4;
                instr_reg <= imem_rdata;
            end else if (valid_reg && out_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a directed vector table for the listed corner cases,
// then randomized traffic checked against a cycle-level behavioural model.

module tb_fetch_stage;
    localparam logic [63:0] RPC = 64'h1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_taken;
    logic [63:0] br_base_pc;
    logic [63:0] br_offset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [63:0] out_pc_plus4;
    logic [31:0] out_instr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk          (clk),
        .reset        (reset),
        .br_taken     (br_taken),
        .br_base_pc   (br_base_pc),
        .br_offset    (br_offset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4),
        .out_instr    (out_instr)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        ordy;
        logic        br;
        logic [63:0] base;
        logic [63:0] off;
        logic        req;
        logic [63:0] addr;
        logic        valid;
        logic [63:0] opc;
        logic [63:0] op4;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic rdy, input logic ordy, input logic br,
                                input logic [63:0] base, input logic [63:0] off,
                                input logic req, input logic [63:0] addr, input logic valid,
                                input logic [63:0] opc, input logic [63:0] op4, input logic [31:0] instr);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.ordy = ordy; v.br = br; v.base = base; v.off = off;
        v.req = req; v.addr = addr; v.valid = valid; v.opc = opc; v.op4 = op4; v.instr = instr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model state
    logic [63:0] m_pc;
    logic        m_valid;
    logic [63:0] m_opc, m_op4;
    logic [31:0] m_instr;
    logic        m_after_reset;
    logic        m_stalled;
    logic        m_req;
    logic        m_acc;

    localparam logic [63:0] WRAP = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        reset = 1'b0; br_taken = 1'b0; br_base_pc = '0; br_offset = '0;
        imem_ready = 1'b0; imem_rdata = '0; out_ready = 1'b0;

        //            rst rdy ordy br base           off            req addr        v  opc          op4          instr
        vecs.push_back(mk(0, 1, 1, 0, 64'h0,        64'h0,         0, 64'h1000, 0, 64'h0,    64'h0,    32'h0));
        vecs.push_back(mk(1, 1, 1, 0, 64'h0,        64'h0,         0, 64'h1000, 0, 64'h0,    64'h0,    32'h0));
        vecs.push_back(mk(1, 1, 1, 0, 64'h0,        64'h0,         1, 64'h1000, 0, 64'h0,    64'h0,    32'h0));
        vecs.push_back(mk(1, 1, 1, 0, 64'h0,        64'h0,         1, 64'h1004, 1, 64'h1000, 64'h1004, 32'h1000));
        vecs.push_back(mk(1, 1, 1, 0, 64'h0,        64'h0,         1, 64'h1008, 1, 64'h1004, 64'h1008, 32'h1004));
        vecs.push_back(mk(1, 1, 0, 0, 64'h0,        64'h0,         0, 64'h100C, 1, 64'h1008, 64'h100C, 32'h1008));
        vecs.push_back(mk(1, 1, 0, 0, 64'h0,        64'h0,         0, 64'h100C, 1, 64'h1008, 64'h100C, 32'h1008));
        vecs.push_back(mk(1, 1, 0, 0, 64'h0,        64'h0,         0, 64'h100C, 1, 64'h1008, 64'h100C, 32'h1008));
        vecs.push_back(mk(1, 1, 1, 0, 64'h0,        64'h0,         0, 64'h100C, 1, 64'h1008, 64'h100C, 32'h1008));
        vecs.push_back(mk(1, 1, 1, 0, 64'h0,        64'h0,         1, 64'h100C, 0, 64'h1008, 64'h100C, 32'h1008));
        vecs.push_back(mk(1, 0, 1, 0, 64'h0,        64'h0,         1, 64'h1010, 1, 64'h100C, 64'h1010, 32'h100C));
        vecs.push_back(mk(1, 0, 1, 0, 64'h0,        64'h0,         1, 64'h1010, 0, 64'h100C, 64'h1010, 32'h100C));
        vecs.push_back(mk(1, 1, 1, 0, 64'h0,        64'h0,         1, 64'h1010, 0, 64'h100C, 64'h1010, 32'h100C));
        vecs.push_back(mk(1, 1, 1, 1, 64'h2000,     -64'd8,        1, 64'h1014, 1, 64'h1010, 64'h1014, 32'h1010));
        vecs.push_back(mk(1, 1, 1, 0, 64'h0,        64'h0,         1, 64'h1FF8, 0, 64'h1010, 64'h1014, 32'h1010));
        vecs.push_back(mk(1, 1, 1, 1, 64'h2000,     64'd6,         1, 64'h1FFC, 1, 64'h1FF8, 64'h1FFC, 32'h1FF8));
        vecs.push_back(mk(1, 1, 1, 0, 64'h0,        64'h0,         1, 64'h2004, 0, 64'h1FF8, 64'h1FFC, 32'h1FF8));
        vecs.push_back(mk(1, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF0, 64'hC, 1, 64'h2008, 1, 64'h2004, 64'h2008, 32'h2004));
        vecs.push_back(mk(1, 1, 1, 0, 64'h0,        64'h0,         1, WRAP,     0, 64'h2004, 64'h2008, 32'h2004));
        vecs.push_back(mk(1, 1, 1, 0, 64'h0,        64'h0,         1, 64'h0,    1, WRAP,     64'h0,    32'hFFFF_FFFC));
        vecs.push_back(mk(1, 1, 1, 0, 64'h0,        64'h0,         1, 64'h4,    1, 64'h0,    64'h4,    32'h0));
        vecs.push_back(mk(1, 1, 0, 0, 64'h0,        64'h0,         0, 64'h8,    1, 64'h4,    64'h8,    32'h4));
        vecs.push_back(mk(0, 1, 0, 1, 64'h3000,     64'h0,         0, 64'h8,    1, 64'h4,    64'h8,    32'h4));
        vecs.push_back(mk(1, 1, 1, 0, 64'h0,        64'h0,         0, 64'h1000, 0, 64'h0,    64'h0,    32'h0));
        vecs.push_back(mk(1, 1, 1, 0, 64'h0,        64'h0,         1, 64'h1000, 0, 64'h0,    64'h0,    32'h0));

        repeat (2) @(negedge clk);

        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk);
            reset      = vecs[r].rst;
            imem_ready = vecs[r].rdy;
            out_ready  = vecs[r].ordy;
            br_taken   = vecs[r].br;
            br_base_pc = vecs[r].base;
            br_offset  = vecs[r].off;
            imem_rdata = vecs[r].addr[31:0];
            #1;
            $display("vec %0d: req=%b addr=%h valid=%b pc=%h instr=%h", r, imem_req, imem_addr, out_valid, out_pc, out_instr);
            chk($sformatf("vec%0d imem_req", r), imem_req, vecs[r].req);
            chk($sformatf("vec%0d imem_addr", r), imem_addr, vecs[r].addr);
            chk($sformatf("vec%0d out_valid", r), out_valid, vecs[r].valid);
            chk($sformatf("vec%0d out_pc", r), out_pc, vecs[r].opc);
            chk($sformatf("vec%0d out_pc_plus4", r), out_pc_plus4, vecs[r].op4);
            chk($sformatf("vec%0d out_instr", r), out_instr, vecs[r].instr);
        end

        // Randomized traffic against the model; cycle 0 forces reset to align both.
        m_pc = '0; m_valid = 0; m_opc = '0; m_op4 = '0; m_instr = '0;
        m_after_reset = 1; m_stalled = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            reset      = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
            imem_ready = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 7);
            br_taken   = ($urandom_range(0, 15) == 0);
            br_base_pc = ($urandom_range(0, 7) == 0) ? WRAP : {32'd0, $urandom};
            br_offset  = {{32{1'b0}}, $urandom} - 64'h8000_0000;
            imem_rdata = $urandom;
            m_req = reset && !m_after_reset && !m_stalled && (!m_valid || out_ready);
            m_acc = m_req && imem_ready && !br_taken;
            #1;
            if (i != 0) begin
                chk("rnd imem_req", imem_req, m_req);
                chk("rnd imem_addr", imem_addr, m_pc);
                chk("rnd out_valid", out_valid, m_valid);
                chk("rnd out_pc", out_pc, m_opc);
                chk("rnd out_pc_plus4", out_pc_plus4, m_op4);
                chk("rnd out_instr", out_instr, m_instr);
                if (m_acc) $display("rnd %0d: fetch pc=%h instr=%h", i, m_pc, imem_rdata);
            end
            @(posedge clk);
            if (!reset) begin
                m_pc = RPC; m_valid = 0; m_opc = '0; m_op4 = '0; m_instr = '0;
                m_after_reset = 1; m_stalled = 0;
            end else if (br_taken) begin
                m_pc = (br_base_pc + br_offset) & ~64'd3;
                m_valid = 0; m_after_reset = 0; m_stalled = 0;
            end else begin
                if (m_after_reset)  m_stalled = 0;
                else if (m_stalled) m_stalled = !out_ready;
                else                m_stalled = m_valid && !out_ready;
                m_after_reset = 0;
                if (m_acc) begin
                    m_opc = m_pc; m_op4 = m_pc + 64'd4; m_instr = imem_rdata;
                    m_valid = 1; m_pc = m_pc + 64'd4;
                end else if (m_valid && out_ready) begin
                    m_valid = 0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
